// File: rtl/key_loader_if.sv
// key_loader pin bundle: load strobe, nibble bus, clear and
// the committed key with its status flags.
interface key_loader_if #(
  parameter int KEY_WIDTH = 16
) ();
  logic                 load_key;
  logic [3:0]           key_data;
  logic                 clear;
  logic [KEY_WIDTH-1:0] key;
  logic                 key_valid;
  logic                 error;
  logic                 locked;
  logic                 busy;

  modport master (
    output load_key, key_data, clear,
    input  key, key_valid, error, locked, busy
  );

  modport slave (
    input  load_key, key_data, clear,
    output key, key_valid, error, locked, busy
  );
endinterface

// File: rtl/key_loader.sv
// key_loader: framed serial key entry with checksum
// verification and lockout after repeated bad frames.
module key_loader #(
  parameter int KEY_WIDTH = 16,
  parameter int MAX_FAILS = 3
) (
  input logic         clk,
  input logic         rst_n,
  key_loader_if.slave bus
);
  localparam int NIBBLES = KEY_WIDTH / 4;
  localparam int CW = $clog2(NIBBLES + 1);

  typedef enum logic [2:0] {
    IDLE, SHIFT, CHECK, DONE, ERR, LOCK
  } state_t;

  state_t               state;
  logic                 load_d;
  logic [KEY_WIDTH-1:0] shift;
  logic [3:0]           csum;
  logic [CW-1:0]        cnt;
  logic [3:0]           fails;
  logic [KEY_WIDTH-1:0] key_q;
  logic                 valid_q;
  logic                 error_q;
  logic                 locked_q;
  logic                 busy_q;

  logic                 ev;
  logic [KEY_WIDTH+3:0] shl;
  logic [3:0]           fails_n;

  assign ev      = bus.load_key & ~load_d;
  assign shl     = {shift, bus.key_data};
  assign fails_n = fails + 4'd1;

  // Frame FSM: edge detect, nibble shift, checksum and lockout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      load_d   <= 1'b0;
      shift    <= '0;
      csum     <= '0;
      cnt      <= '0;
      fails    <= '0;
      key_q    <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      locked_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      load_d <= bus.load_key;
      if (bus.clear && state != LOCK) begin
        state   <= IDLE;
        shift   <= '0;
        csum    <= '0;
        cnt     <= '0;
        key_q   <= '0;
        valid_q <= 1'b0;
        error_q <= 1'b0;
        busy_q  <= 1'b0;
      end else if (ev) begin
        case (state)
          IDLE, SHIFT: begin
            shift  <= shl[KEY_WIDTH-1:0];
            csum   <= csum ^ bus.key_data;
            cnt    <= cnt + CW'(1);
            busy_q <= 1'b1;
            if (cnt == CW'(NIBBLES - 1))
              state <= CHECK;
            else
              state <= SHIFT;
          end
          CHECK: begin
            busy_q <= 1'b0;
            if (bus.key_data == (csum ^ 4'hA)) begin
              key_q   <= shift;
              valid_q <= 1'b1;
              error_q <= 1'b0;
              state   <= DONE;
            end else begin
              error_q <= 1'b1;
              fails   <= fails_n;
              if (fails_n == 4'(MAX_FAILS)) begin
                state    <= LOCK;
                locked_q <= 1'b1;
                key_q    <= '0;
                valid_q  <= 1'b0;
              end else begin
                state <= ERR;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.key       = key_q;
  assign bus.key_valid = valid_q;
  assign bus.error     = error_q;
  assign bus.locked    = locked_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_key_loader.sv
// Directed bench for key_loader: valid/bad frames, lockout,
// held strobe, clear collision and async reset mid-frame.
module tb_key_loader;
  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total;

  key_loader_if #(.KEY_WIDTH(16)) bus ();

  key_loader #(
    .KEY_WIDTH(16),
    .MAX_FAILS(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  task automatic nib(input logic [3:0] d);
    @(negedge clk);
    bus.load_key = 1'b1;
    bus.key_data = d;
    @(negedge clk);
    bus.load_key = 1'b0;
  endtask

  task automatic frame(input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d,
                       input logic [3:0] s);
    nib(a);
    nib(b);
    nib(c);
    nib(d);
    nib(s);
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic status(input string tag,
                        input logic [15:0] k, input logic v,
                        input logic e, input logic l,
                        input logic b);
    chk({tag, ".key"}, 32'(bus.key), 32'(k));
    chk({tag, ".valid"}, 32'(bus.key_valid), 32'(v));
    chk({tag, ".error"}, 32'(bus.error), 32'(e));
    chk({tag, ".locked"}, 32'(bus.locked), 32'(l));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
  endtask

  initial begin
    pass_cnt     = 0;
    total        = 0;
    rst_n        = 1'b0;
    bus.load_key = 1'b0;
    bus.key_data = 4'h0;
    bus.clear    = 1'b0;
    #12;
    status("reset", 16'h0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // valid frame 1,2,3,4 checksum E
    nib(4'h1);
    chk("mid.busy", 32'(bus.busy), 32'd1);
    nib(4'h2);
    nib(4'h3);
    nib(4'h4);
    chk("check.busy", 32'(bus.busy), 32'd1);
    chk("check.valid", 32'(bus.key_valid), 32'd0);
    nib(4'hE);
    status("good", 16'h1234, 1, 0, 0, 0);

    // DONE ignores loads, clear drops key, new frame
    nib(4'h9);
    status("done_ign", 16'h1234, 1, 0, 0, 0);
    do_clear();
    status("done_clr", 16'h0, 0, 0, 0, 0);
    frame(4'h5, 4'h6, 4'h7, 4'h8, 4'h6);
    status("reentry", 16'h5678, 1, 0, 0, 0);

    // bad checksum
    do_clear();
    frame(4'h1, 4'h2, 4'h3, 4'h4, 4'hF);
    status("bad", 16'h0, 0, 1, 0, 0);
    nib(4'hE);
    status("bad_ign", 16'h0, 0, 1, 0, 0);
    do_clear();
    status("bad_clr", 16'h0, 0, 0, 0, 0);

    // lockout after three bad frames
    do_reset();
    frame(4'h1, 4'h2, 4'h3, 4'h4, 4'h0);
    status("bad1", 16'h0, 0, 1, 0, 0);
    do_clear();
    frame(4'h1, 4'h2, 4'h3, 4'h4, 4'h1);
    status("bad2", 16'h0, 0, 1, 0, 0);
    do_clear();
    frame(4'h1, 4'h2, 4'h3, 4'h4, 4'h2);
    status("lock", 16'h0, 0, 1, 1, 0);
    do_clear();
    status("lock_clr", 16'h0, 0, 1, 1, 0);
    frame(4'h1, 4'h2, 4'h3, 4'h4, 4'hE);
    status("lock_ld", 16'h0, 0, 1, 1, 0);
    do_reset();
    status("unlock", 16'h0, 0, 0, 0, 0);
    frame(4'h1, 4'h2, 4'h3, 4'h4, 4'hE);
    status("post_lock", 16'h1234, 1, 0, 0, 0);

    // held strobe captures one nibble
    do_clear();
    @(negedge clk);
    bus.load_key = 1'b1;
    bus.key_data = 4'h7;
    repeat (5) @(negedge clk);
    bus.load_key = 1'b0;
    status("held", 16'h0, 0, 0, 0, 1);
    nib(4'h1);
    nib(4'h2);
    nib(4'h3);
    nib(4'hD);
    status("held_frm", 16'h7123, 1, 0, 0, 0);

    // clear colliding with a load event discards nibble
    do_clear();
    @(negedge clk);
    bus.clear    = 1'b1;
    bus.load_key = 1'b1;
    bus.key_data = 4'h9;
    @(negedge clk);
    bus.clear    = 1'b0;
    @(negedge clk);
    bus.load_key = 1'b0;
    status("collide", 16'h0, 0, 0, 0, 0);
    frame(4'h1, 4'h2, 4'h3, 4'h4, 4'hE);
    status("coll_frm", 16'h1234, 1, 0, 0, 0);

    // async reset mid-frame
    do_clear();
    nib(4'hA);
    nib(4'hB);
    chk("pre_rst.busy", 32'(bus.busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    status("async", 16'h0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    frame(4'hA, 4'hB, 4'hC, 4'hD, 4'hA);
    status("abcd", 16'hABCD, 1, 0, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
